alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle controller that drives the 4-bit ADD/NAND ALU (sel=0 SUM, sel=1 NAND).
//  Builds compound ops (NOT, AND, OR, SUB, INC, XOR) from repeated single-cycle ALU passes.
//  Sits between instruction decode (request side) and one external alu instance.
//  Holds operands and temporaries in registers; one ALU pass per clock.
// PARAMETERS
//  DATA_W  4  operand/result width; must equal the ALU width
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       controller idle, request accepted when req_valid&req_ready
//  op         in   3       opcode, sampled at accept
//  A          in   DATA_W  operand A, sampled at accept
//  B          in   DATA_W  operand B, sampled at accept
//  RES        out  DATA_W  result, valid while res_valid
//  res_valid  out  1       result held until res_ready
//  res_ready  in   1       consumer takes result
//  res_err    out  1       illegal opcode flag, qualified by res_valid
//  busy       out  1       high in EXEC or DONE
//  alu_a      out  DATA_W  ALU operand A
//  alu_b      out  DATA_W  ALU operand B
//  alu_sel    out  1       0=SUM, 1=NAND
//  alu_res    in   DATA_W  ALU result (combinational, same cycle)
// BEHAVIOUR
//  States: IDLE -> EXEC -> DONE -> IDLE. Registers: ra, rb, rop, T0, T1, step[1:0].
//  rst (any state, mid-operation included): state=IDLE, step=0, RES=0, res_valid=0,
//   res_err=0, busy=0, alu_a=alu_b=0, alu_sel=0; req_ready=0 while rst high.
//  IDLE: req_ready=1. On accept: latch op/A/B, step=0, go EXEC. Illegal op: go DONE directly,
//   RES=0, res_err=1 (1-cycle latency).
//  EXEC: each cycle drive alu_* per schedule(rop,step), capture alu_res into dest at clock edge.
//   Last pass writes RES, sets res_valid=1, go DONE. Latency accept->res_valid = N passes.
//  Schedule (N passes), all arithmetic mod 2^DATA_W, no carry kept:
//   000 ADD  N=1: RES=ADD(a,b)
//   001 NAND N=1: RES=NAND(a,b)
//   010 NOT  N=1: RES=NAND(a,a)
//   011 AND  N=2: T0=NAND(a,b); RES=NAND(T0,T0)
//   100 OR   N=3: T0=NAND(a,a); T1=NAND(b,b); RES=NAND(T0,T1)
//   101 SUB  N=3: T0=NAND(b,b); T0=ADD(a,T0); RES=ADD(T0,1)
//   110 INC  N=1: RES=ADD(a,1)
//   111 XOR  N=4: T0=NAND(a,b); T1=NAND(a,T0); T0=NAND(b,T0); RES=NAND(T1,T0)
//  DONE: RES/res_err stable; on res_ready drop res_valid, go IDLE (next accept one cycle later,
//   no same-cycle back-to-back). req_valid ignored outside IDLE; op/A/B changes ignored after accept.
//  alu_* outside EXEC: hold 0.
// CONFIGURATION
//  XOR_OP_EN defined: opcode 111 = XOR as scheduled above.
//  XOR_OP_EN undefined: opcode 111 illegal -> DONE next cycle, RES=0, res_err=1, no ALU pass.
// STRUCTURE
//  Package alu_seq_pkg: opcode localparams, state encoding, per-op pass count table,
//   operand-source codes (SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_ONE), dest codes (T0, T1, RES).
//  Sub-module alu_seq_rom: combinational (op, step) -> {src_a, src_b, alu_sel, dest, last, illegal}.
//  Top keeps FSM, operand/temp registers, output handshake.
// TESTING
//  ADD A=4'h9 B=4'h8 -> res_valid 1 cycle after accept, RES=4'h1, res_err=0
//  SUB A=4'h3 B=4'h5 -> 3 passes, alu_sel seq 1,0,0, RES=4'hE
//  XOR A=4'hC B=4'hA (XOR_OP_EN) -> 4 passes all sel=1, RES=4'h6; without macro -> RES=0, res_err=1
//  OR A=4'h4 B=4'h1, res_ready low 5 cycles -> RES=4'h5 held, req_ready=0 until release
//  rst high during pass 2 of XOR -> next cycle IDLE, res_valid=0, req_ready=1 after rst drops
//  AND A=4'hF B=4'h6, req_valid held high with new op -> second op accepted only after DONE, RES=4'h6

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: opcodes, FSM states, micro-op fields.
// XOR_OP_EN enables opcode 111 (XOR); without it that opcode is illegal.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NAND = 3'b001;
  localparam logic [2:0] OP_NOT  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2} state_t;
  typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T0, SRC_T1, SRC_ONE} src_t;
  typedef enum logic [1:0] {DST_T0, DST_T1, DST_RES} dest_t;

  typedef struct packed {
    src_t  src_a;
    src_t  src_b;
    logic  alu_sel;
    dest_t dest;
    logic  last;
    logic  illegal;
  } uop_t;

  // Number of ALU passes per opcode; 0 means the opcode is rejected.
  function automatic logic [2:0] op_passes(input logic [2:0] op);
    case (op)
      OP_AND:         op_passes = 3'd2;
      OP_OR, OP_SUB:  op_passes = 3'd3;
`ifdef XOR_OP_EN
      OP_XOR:         op_passes = 3'd4;
`else
      OP_XOR:         op_passes = 3'd0;
`endif
      default:        op_passes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake and external ALU bus of the op sequencer.
interface alu_op_sequencer_if #(parameter int DATA_W = 4);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        op;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [DATA_W-1:0] RES;
  logic              res_valid;
  logic              res_ready;
  logic              res_err;
  logic              busy;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_sel;
  logic [DATA_W-1:0] alu_res;

  modport slave (
    input  req_valid, op, A, B, res_ready, alu_res,
    output req_ready, RES, res_valid, res_err, busy, alu_a, alu_b, alu_sel
  );

  modport master (
    output req_valid, op, A, B, res_ready, alu_res,
    input  req_ready, RES, res_valid, res_err, busy, alu_a, alu_b, alu_sel
  );
endinterface

// File: rtl/alu_seq_rom.sv
// Micro-op table: (opcode, pass index) -> ALU operand sources, select, destination.
// XOR_OP_EN selects whether opcode 111 has a schedule or is flagged illegal.
module alu_seq_rom
  import alu_seq_pkg::*;
(
  input  logic [2:0] i_op,
  input  logic [1:0] i_step,
  output uop_t       o_uop
);

  function automatic uop_t mk(input src_t sa, input src_t sb, input logic sel,
                              input dest_t dst, input logic last);
    mk = '{src_a: sa, src_b: sb, alu_sel: sel, dest: dst, last: last, illegal: 1'b0};
  endfunction

  always_comb begin
    o_uop = mk(SRC_A, SRC_B, 1'b0, DST_RES, 1'b1);
    case (i_op)
      OP_ADD:  o_uop = mk(SRC_A, SRC_B,   1'b0, DST_RES, 1'b1);
      OP_NAND: o_uop = mk(SRC_A, SRC_B,   1'b1, DST_RES, 1'b1);
      OP_NOT:  o_uop = mk(SRC_A, SRC_A,   1'b1, DST_RES, 1'b1);
      OP_INC:  o_uop = mk(SRC_A, SRC_ONE, 1'b0, DST_RES, 1'b1);
      OP_AND:
        case (i_step)
          2'd0:    o_uop = mk(SRC_A,  SRC_B,  1'b1, DST_T0,  1'b0);
          default: o_uop = mk(SRC_T0, SRC_T0, 1'b1, DST_RES, 1'b1);
        endcase
      OP_OR:
        case (i_step)
          2'd0:    o_uop = mk(SRC_A,  SRC_A,  1'b1, DST_T0,  1'b0);
          2'd1:    o_uop = mk(SRC_B,  SRC_B,  1'b1, DST_T1,  1'b0);
          default: o_uop = mk(SRC_T0, SRC_T1, 1'b1, DST_RES, 1'b1);
        endcase
      // Two's complement subtract: a + ~b + 1, carry dropped
      OP_SUB:
        case (i_step)
          2'd0:    o_uop = mk(SRC_B,  SRC_B,   1'b1, DST_T0,  1'b0);
          2'd1:    o_uop = mk(SRC_A,  SRC_T0,  1'b0, DST_T0,  1'b0);
          default: o_uop = mk(SRC_T0, SRC_ONE, 1'b0, DST_RES, 1'b1);
        endcase
      OP_XOR: begin
`ifdef XOR_OP_EN
        case (i_step)
          2'd0:    o_uop = mk(SRC_A,  SRC_B,  1'b1, DST_T0,  1'b0);
          2'd1:    o_uop = mk(SRC_A,  SRC_T0, 1'b1, DST_T1,  1'b0);
          2'd2:    o_uop = mk(SRC_B,  SRC_T0, 1'b1, DST_T0,  1'b0);
          default: o_uop = mk(SRC_T1, SRC_T0, 1'b1, DST_RES, 1'b1);
        endcase
`else
        o_uop.illegal = 1'b1;
`endif
      end
      default: o_uop.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller building compound ops from single ADD/NAND ALU passes.
// XOR_OP_EN (see alu_seq_rom) enables the four-pass XOR opcode.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);

  state_t            r_state;
  logic [1:0]        r_step;
  logic [2:0]        r_rop;
  logic [DATA_W-1:0] r_ra, r_rb, r_t0, r_t1, r_res;
  logic [DATA_W-1:0] r_alu_a, r_alu_b;
  logic              r_alu_sel, r_res_valid, r_res_err, r_busy, r_last;
  dest_t             r_dest;

  logic              w_idle, w_exec, w_accept;
  logic [2:0]        w_rom_op;
  logic [1:0]        w_rom_step;
  uop_t              w_uop;
  logic [DATA_W-1:0] w_t0_nxt, w_t1_nxt, w_opa, w_opb, w_nxt_a, w_nxt_b;

  function automatic logic [DATA_W-1:0] pick(input src_t s, input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic [DATA_W-1:0] t0,
                                             input logic [DATA_W-1:0] t1);
    case (s)
      SRC_A:   pick = a;
      SRC_B:   pick = b;
      SRC_T0:  pick = t0;
      SRC_T1:  pick = t1;
      default: pick = {{(DATA_W-1){1'b0}}, 1'b1};
    endcase
  endfunction

  assign w_idle   = (r_state == ST_IDLE);
  assign w_exec   = (r_state == ST_EXEC);
  assign w_accept = bus.req_valid && w_idle && !rst;

  // The table is looked up one pass ahead so ALU drive lines can be registered
  assign w_rom_op   = w_idle ? bus.op : r_rop;
  assign w_rom_step = w_idle ? 2'd0 : r_step + 2'd1;

  alu_seq_rom u_rom (
    .i_op   (w_rom_op),
    .i_step (w_rom_step),
    .o_uop  (w_uop)
  );

  assign w_t0_nxt = (w_exec && r_dest == DST_T0) ? bus.alu_res : r_t0;
  assign w_t1_nxt = (w_exec && r_dest == DST_T1) ? bus.alu_res : r_t1;
  assign w_opa    = w_idle ? bus.A : r_ra;
  assign w_opb    = w_idle ? bus.B : r_rb;
  assign w_nxt_a  = pick(w_uop.src_a, w_opa, w_opb, w_t0_nxt, w_t1_nxt);
  assign w_nxt_b  = pick(w_uop.src_b, w_opa, w_opb, w_t0_nxt, w_t1_nxt);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ra  <= bus.A;
      r_rb  <= bus.B;
      r_rop <= bus.op;
    end
    if (w_exec) begin
      r_t0 <= w_t0_nxt;
      r_t1 <= w_t1_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_step      <= 2'd0;
      r_res       <= '0;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= 1'b0;
      r_dest      <= DST_RES;
      r_last      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_step <= 2'd0;
            r_busy <= 1'b1;
            if (w_uop.illegal) begin
              r_state     <= ST_DONE;
              r_res       <= '0;
              r_res_err   <= 1'b1;
              r_res_valid <= 1'b1;
            end else begin
              r_state   <= ST_EXEC;
              r_res_err <= 1'b0;
              r_alu_a   <= w_nxt_a;
              r_alu_b   <= w_nxt_b;
              r_alu_sel <= w_uop.alu_sel;
              r_dest    <= w_uop.dest;
              r_last    <= w_uop.last;
            end
          end
        end
        ST_EXEC: begin
          if (r_last) begin
            r_res       <= bus.alu_res;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= 1'b0;
          end else begin
            r_step    <= r_step + 2'd1;
            r_alu_a   <= w_nxt_a;
            r_alu_b   <= w_nxt_b;
            r_alu_sel <= w_uop.alu_sel;
            r_dest    <= w_uop.dest;
            r_last    <= w_uop.last;
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = w_idle && !rst;
  assign bus.RES       = r_res;
  assign bus.res_valid = r_res_valid;
  assign bus.res_err   = r_res_err;
  assign bus.busy      = r_busy;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_op_sequencer;
  localparam int DATA_W = 4;
`ifdef XOR_OP_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(DATA_W)) bus ();
  alu_op_sequencer #(.DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.alu_res = bus.alu_sel ? ~(bus.alu_a & bus.alu_b) : 4'(bus.alu_a + bus.alu_b);

  typedef struct packed {
    logic [3:0] res;
    logic       err;
    logic [2:0] n;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic exp_t model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.err = 1'b0;
    case (op)
      3'd0: begin e.res = 4'(a + b);    e.n = 3'd1; end
      3'd1: begin e.res = ~(a & b);     e.n = 3'd1; end
      3'd2: begin e.res = ~a;           e.n = 3'd1; end
      3'd3: begin e.res = a & b;        e.n = 3'd2; end
      3'd4: begin e.res = a | b;        e.n = 3'd3; end
      3'd5: begin e.res = 4'(a - b);    e.n = 3'd3; end
      3'd6: begin e.res = 4'(a + 4'd1); e.n = 3'd1; end
      default: begin
        if (XOR_EN) begin e.res = a ^ b; e.n = 3'd4; end
        else begin e.res = 4'd0; e.err = 1'b1; e.n = 3'd0; end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input bit keep);
    int w;
    w = 0;
    while (!bus.req_ready && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) chk("ready_timeout", 8'(bus.req_ready), 8'd1);
    bus.req_valid = 1'b1;
    bus.op = op;
    bus.A = a;
    bus.B = b;
    sb.push_back(model(op, a, b));
    tick();
    if (!keep) bus.req_valid = 1'b0;
  endtask

  task automatic finish(input int hold, output logic [7:0] seq, output int n);
    exp_t e;
    seq = 8'd0;
    n = 0;
    while (!bus.res_valid && n < 8) begin
      seq = {seq[6:0], bus.alu_sel};
      chk("ready_in_exec", 8'(bus.req_ready), 8'd0);
      tick();
      n++;
    end
    e = sb.pop_front();
    chk("latency", 8'(n), 8'(e.n));
    chk("res", 8'(bus.RES), 8'(e.res));
    chk("err", 8'(bus.res_err), 8'(e.err));
    chk("busy_done", 8'(bus.busy), 8'd1);
    chk("alu_sel_done", 8'(bus.alu_sel), 8'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("res_held", 8'(bus.RES), 8'(e.res));
      chk("valid_held", 8'(bus.res_valid), 8'd1);
      chk("ready_held", 8'(bus.req_ready), 8'd0);
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("valid_drop", 8'(bus.res_valid), 8'd0);
    chk("ready_idle", 8'(bus.req_ready), 8'd1);
    chk("busy_idle", 8'(bus.busy), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq;
    int         n;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.op = 3'd0;
    bus.A = 4'd0;
    bus.B = 4'd0;
    repeat (3) tick();
    chk("rst_valid", 8'(bus.res_valid), 8'd0);
    chk("rst_ready", 8'(bus.req_ready), 8'd0);
    chk("rst_busy", 8'(bus.busy), 8'd0);
    chk("rst_res", 8'(bus.RES), 8'd0);
    chk("rst_alu_a", 8'(bus.alu_a), 8'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 8'(bus.req_ready), 8'd1);

    issue(3'd0, 4'h9, 4'h8, 1'b0);
    finish(0, seq, n);

    issue(3'd5, 4'h3, 4'h5, 1'b0);
    finish(0, seq, n);
    chk("sub_sel_seq", {5'd0, seq[2:0]}, 8'b0000_0100);

    issue(3'd7, 4'hC, 4'hA, 1'b0);
    finish(0, seq, n);
    if (XOR_EN) chk("xor_sel_seq", {4'd0, seq[3:0]}, 8'h0F);

    issue(3'd4, 4'h4, 4'h1, 1'b0);
    finish(5, seq, n);

    for (int i = 0; i < 12; i++) begin
      issue(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0);
      finish(i % 2, seq, n);
    end

    // Reset while the second pass is being driven
    issue(XOR_EN ? 3'd7 : 3'd5, 4'hC, 4'hA, 1'b0);
    void'(sb.pop_front());
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_valid", 8'(bus.res_valid), 8'd0);
    chk("midrst_busy", 8'(bus.busy), 8'd0);
    chk("midrst_sel", 8'(bus.alu_sel), 8'd0);
    chk("midrst_res", 8'(bus.RES), 8'd0);
    chk("midrst_ready", 8'(bus.req_ready), 8'd0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", 8'(bus.req_ready), 8'd1);

    issue(3'd3, 4'hF, 4'h6, 1'b1);
    bus.op = 3'd0;
    bus.A = 4'h2;
    bus.B = 4'h3;
    finish(2, seq, n);
    issue(3'd0, 4'h2, 4'h3, 1'b0);
    finish(0, seq, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
